// File: rtl/uart_apb_pkg.sv
// ============================================================================
// Module      : uart_apb_pkg
// Description : Register map and bit positions shared by the UART register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_apb_pkg;

    localparam logic [2:0] ADDR_TXDATA = 3'd0;
    localparam logic [2:0] ADDR_RXDATA = 3'd1;
    localparam logic [2:0] ADDR_STATUS = 3'd2;
    localparam logic [2:0] ADDR_CTRL   = 3'd3;
    localparam logic [2:0] ADDR_BAUD   = 3'd4;

    localparam int CTRL_TX_EN      = 0;
    localparam int CTRL_RX_EN      = 1;
    localparam int CTRL_PARITY_EN  = 2;
    localparam int CTRL_PARITY_ODD = 3;
    localparam int CTRL_IE         = 4;

    localparam int STAT_TX_EMPTY = 0;
    localparam int STAT_TX_FULL  = 1;
    localparam int STAT_RX_EMPTY = 2;
    localparam int STAT_RX_FULL  = 3;
    localparam int STAT_TX_OVF   = 4;
    localparam int STAT_RX_OVF   = 5;

endpackage

`default_nettype wire

// File: rtl/uart_sync_fifo.sv
// ============================================================================
// Module      : uart_sync_fifo
// Description : Single-clock FIFO with combinational head; a pop frees a slot
//               for a push in the same cycle, a pop on empty is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        din,
    output logic [WIDTH-1:0]        dout,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (AW+1)'(DEPTH));
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)
                r_count <= r_count + 1'b1;
            else if (!w_do_push && w_do_pop)
                r_count <= r_count - 1'b1;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

endmodule

`default_nettype wire

// File: rtl/uart_apb_regs.sv
// ============================================================================
// Module      : uart_apb_regs
// Description : UART register file with TX/RX FIFOs, read mux and level irq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_apb_regs
    import uart_apb_pkg::*;
#(
    parameter int          FIFO_DEPTH = 16,
    parameter int          ADDR_W     = 5,
    parameter logic [15:0] BAUD_RST   = 16'd27
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [4:0]        ctrl_out,
    output logic [15:0]       baud_div,
    output logic              irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [4:0]  r_ctrl;
    logic [15:0] r_baud;
    logic        r_tx_ovf, r_rx_ovf, r_irq;

    logic [2:0]  w_sel;
    logic        w_wr_tx, w_wr_stat, w_wr_ctrl, w_wr_baud, w_rd_rx;
    logic        w_tx_pop, w_tx_push_eff, w_rx_push, w_rx_pop_eff, w_rx_push_eff;
    logic        w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic [7:0]  w_tx_head, w_rx_head;
    logic [CW-1:0] w_tx_count, w_rx_count, w_tx_cnt_nxt, w_rx_cnt_nxt;
    logic        w_tx_ovf_nxt, w_rx_ovf_nxt;
    logic [4:0]  w_ctrl_nxt;
    logic [31:0] w_status, w_rdata;
    logic        w_unused;

    assign w_sel     = paddr[4:2];
    assign w_wr_tx   = wr_en && (w_sel == ADDR_TXDATA);
    assign w_wr_stat = wr_en && (w_sel == ADDR_STATUS);
    assign w_wr_ctrl = wr_en && (w_sel == ADDR_CTRL);
    assign w_wr_baud = wr_en && (w_sel == ADDR_BAUD);
    assign w_rd_rx   = rd_en && !wr_en && (w_sel == ADDR_RXDATA);
    assign w_unused  = &{1'b0, paddr, pwdata};

    assign tx_valid  = !w_tx_empty && r_ctrl[CTRL_TX_EN];
    assign tx_data   = w_tx_empty ? 8'd0 : w_tx_head;
    assign w_tx_pop  = tx_valid && tx_ready;
    assign w_rx_push = rx_valid && r_ctrl[CTRL_RX_EN];

    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(sys_clk), .rst(sys_rst), .push(w_wr_tx), .pop(w_tx_pop),
        .din(pwdata[7:0]), .dout(w_tx_head), .full(w_tx_full),
        .empty(w_tx_empty), .count(w_tx_count)
    );

    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(sys_clk), .rst(sys_rst), .push(w_rx_push), .pop(w_rd_rx),
        .din(rx_data), .dout(w_rx_head), .full(w_rx_full),
        .empty(w_rx_empty), .count(w_rx_count)
    );

    // Next-state view of the FIFOs lets irq follow its cause by exactly one cycle.
    assign w_tx_push_eff = w_wr_tx && (!w_tx_full || w_tx_pop);
    assign w_rx_pop_eff  = w_rd_rx && !w_rx_empty;
    assign w_rx_push_eff = w_rx_push && (!w_rx_full || w_rx_pop_eff);
    assign w_tx_cnt_nxt  = w_tx_count + CW'(w_tx_push_eff) - CW'(w_tx_pop);
    assign w_rx_cnt_nxt  = w_rx_count + CW'(w_rx_push_eff) - CW'(w_rx_pop_eff);

    assign w_tx_ovf_nxt = (w_wr_tx && w_tx_full && !w_tx_pop)
                        || (r_tx_ovf && !(w_wr_stat && pwdata[STAT_TX_OVF]));
    assign w_rx_ovf_nxt = (w_rx_push && w_rx_full && !w_rx_pop_eff)
                        || (r_rx_ovf && !(w_wr_stat && pwdata[STAT_RX_OVF]));
    assign w_ctrl_nxt   = w_wr_ctrl ? pwdata[4:0] : r_ctrl;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_ctrl   <= '0;
            r_baud   <= BAUD_RST;
            r_tx_ovf <= 1'b0;
            r_rx_ovf <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_ctrl   <= w_ctrl_nxt;
            r_tx_ovf <= w_tx_ovf_nxt;
            r_rx_ovf <= w_rx_ovf_nxt;
            if (w_wr_baud)
                r_baud <= (pwdata[15:0] == 16'd0) ? 16'd1 : pwdata[15:0];
            r_irq <= w_ctrl_nxt[CTRL_IE] && ((w_rx_cnt_nxt != '0) || (w_tx_cnt_nxt == '0)
                                             || w_tx_ovf_nxt || w_rx_ovf_nxt);
        end
    end

    assign w_status = {26'd0, r_rx_ovf, r_tx_ovf, w_rx_full, w_rx_empty, w_tx_full, w_tx_empty};

    always_comb begin
        w_rdata = '0;
        case (w_sel)
            ADDR_RXDATA: if (!w_rx_empty) w_rdata = {24'd0, w_rx_head};
            ADDR_STATUS: w_rdata = w_status;
            ADDR_CTRL:   w_rdata = {27'd0, r_ctrl};
            ADDR_BAUD:   w_rdata = {16'd0, r_baud};
            default:     w_rdata = '0;
        endcase
    end

    assign prdata   = (rd_en && !wr_en) ? w_rdata : 32'd0;
    assign ctrl_out = r_ctrl;
    assign baud_div = r_baud;
    assign irq      = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_uart_apb_regs.sv
// ============================================================================
// Module      : tb_uart_apb_regs
// Description : Directed plus randomized bench against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_apb_regs;
    import uart_apb_pkg::*;

    localparam int DEPTH = 16;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        wr_en = 1'b0, rd_en = 1'b0;
    logic [4:0]  paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic [4:0]  ctrl_out;
    logic [15:0] baud_div;
    logic        irq;

    uart_apb_regs #(.FIFO_DEPTH(DEPTH), .ADDR_W(5), .BAUD_RST(16'd27)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .wr_en(wr_en), .rd_en(rd_en),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
        .rx_valid(rx_valid), .ctrl_out(ctrl_out), .baud_div(baud_div), .irq(irq)
    );

    always #5 sys_clk = ~sys_clk;

    int n_assert = 0;
    int n_fail   = 0;

    byte unsigned m_tx[$];
    byte unsigned m_rx[$];
    bit           m_tx_ovf, m_rx_ovf, m_irq;
    bit [4:0]     m_ctrl;
    bit [15:0]    m_baud;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        return {26'd0, m_rx_ovf, m_tx_ovf, (m_rx.size() == DEPTH), (m_rx.size() == 0),
                (m_tx.size() == DEPTH), (m_tx.size() == 0)};
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] sel);
        case (sel)
            ADDR_RXDATA: return (m_rx.size() != 0) ? {24'd0, m_rx[0]} : 32'd0;
            ADDR_STATUS: return m_status();
            ADDR_CTRL:   return {27'd0, m_ctrl};
            ADDR_BAUD:   return {16'd0, m_baud};
            default:     return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_tx.delete();
        m_rx.delete();
        m_tx_ovf = 0; m_rx_ovf = 0; m_irq = 0;
        m_ctrl = '0;  m_baud = 16'd27;
    endtask

    task automatic model_update(input bit wr, input bit rd, input logic [2:0] sel,
                                input logic [31:0] wd, input bit txr, input bit rxv,
                                input logic [7:0] rxd);
        bit tx_set = 0, rx_set = 0;
        bit tx_pop = (m_tx.size() != 0) && m_ctrl[0] && txr;
        bit rx_pop = rd && !wr && (sel == ADDR_RXDATA) && (m_rx.size() != 0);
        if (tx_pop) void'(m_tx.pop_front());
        if (wr && sel == ADDR_TXDATA) begin
            if (m_tx.size() < DEPTH) m_tx.push_back(wd[7:0]);
            else tx_set = 1;
        end
        if (rx_pop) void'(m_rx.pop_front());
        if (rxv && m_ctrl[1]) begin
            if (m_rx.size() < DEPTH) m_rx.push_back(rxd);
            else rx_set = 1;
        end
        if (wr && sel == ADDR_STATUS) begin
            if (wd[4]) m_tx_ovf = 0;
            if (wd[5]) m_rx_ovf = 0;
        end
        if (tx_set) m_tx_ovf = 1;
        if (rx_set) m_rx_ovf = 1;
        if (wr && sel == ADDR_CTRL) m_ctrl = wd[4:0];
        if (wr && sel == ADDR_BAUD) m_baud = (wd[15:0] == 16'd0) ? 16'd1 : wd[15:0];
        m_irq = m_ctrl[4] && ((m_rx.size() != 0) || (m_tx.size() == 0) || m_tx_ovf || m_rx_ovf);
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "/tx_valid"}, 32'(tx_valid), 32'((m_tx.size() != 0) && m_ctrl[0]));
        chk({tag, "/tx_data"},  32'(tx_data),  (m_tx.size() != 0) ? 32'(m_tx[0]) : 32'd0);
        chk({tag, "/irq"},      32'(irq),      32'(m_irq));
        chk({tag, "/ctrl_out"}, 32'(ctrl_out), 32'(m_ctrl));
        chk({tag, "/baud_div"}, 32'(baud_div), 32'(m_baud));
    endtask

    // One bus cycle: drive at negedge, check the read mux, let the edge act, check state.
    task automatic step(input bit wr, input bit rd, input logic [2:0] sel, input logic [31:0] wd,
                        input bit txr, input bit rxv, input logic [7:0] rxd, input string tag);
        @(negedge sys_clk);
        wr_en = wr; rd_en = rd; paddr = {sel, 2'($urandom_range(0, 3))}; pwdata = wd;
        tx_ready = txr; rx_valid = rxv; rx_data = rxd;
        #1;
        if (rd && !wr) chk({tag, "/prdata"}, prdata, m_read(sel));
        else if (!rd)  chk({tag, "/prdata_idle"}, prdata, 32'd0);
        @(posedge sys_clk);
        model_update(wr, rd, sel, wd, txr, rxv, rxd);
        #1;
        wr_en = 0; rd_en = 0; tx_ready = 0; rx_valid = 0;
        check_outputs(tag);
    endtask

    task automatic do_write(input logic [2:0] sel, input logic [31:0] wd, input string tag);
        step(1, 0, sel, wd, 0, 0, 8'd0, tag);
    endtask

    task automatic do_read(input logic [2:0] sel, input string tag);
        step(0, 1, sel, 32'd0, 0, 0, 8'd0, tag);
    endtask

    task automatic async_reset(input string tag);
        @(posedge sys_clk);
        #3;
        sys_rst = 1; wr_en = 0; rd_en = 1; paddr = {ADDR_STATUS, 2'b00};
        tx_ready = 0; rx_valid = 0;
        #1;
        model_reset();
        chk({tag, "/status_now"}, prdata, m_status());
        check_outputs({tag, "_now"});
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 0; rd_en = 0;
    endtask

    logic [2:0]  r_sel;
    logic [31:0] r_wd;
    int          r_k;

    initial begin
        model_reset();
        repeat (2) @(negedge sys_clk);
        sys_rst = 0;

        // Reset values
        do_read(ADDR_STATUS, "rst_status");
        chk("rst_status_const", m_status(), 32'h5);
        do_read(ADDR_CTRL, "rst_ctrl");
        do_read(ADDR_BAUD, "rst_baud");
        do_read(3'd6, "unmapped");

        // Single TX byte
        do_write(ADDR_CTRL, 32'h1, "ctrl_txen");
        do_write(ADDR_TXDATA, 32'hFFFF_FFA5, "tx_a5");
        chk("tx_a5_data", 32'(tx_data), 32'hA5);
        do_read(ADDR_STATUS, "tx_status4");
        step(0, 0, 3'd0, 0, 1, 0, 8'd0, "tx_pop");
        chk("tx_pop_valid", 32'(tx_valid), 32'd0);
        do_read(ADDR_STATUS, "tx_status5");

        // TX overflow and W1C
        do_write(ADDR_CTRL, 32'h0, "ctrl_off");
        for (int i = 0; i <= DEPTH; i++) do_write(ADDR_TXDATA, 32'(i), "tx_fill");
        do_read(ADDR_STATUS, "tx_ovf_status");
        chk("tx_ovf_16", m_status(), 32'h16);
        do_write(ADDR_STATUS, 32'h10, "w1c_tx");
        do_read(ADDR_STATUS, "after_w1c");
        // Pop and push on a full FIFO in the same cycle: no overflow
        do_write(ADDR_CTRL, 32'h1, "ctrl_txen2");
        step(1, 0, ADDR_TXDATA, 32'h77, 1, 0, 8'd0, "tx_full_pushpop");
        do_read(ADDR_STATUS, "tx_full_pp_status");
        for (int i = 0; i < DEPTH; i++) step(0, 0, 3'd0, 0, 1, 0, 8'd0, "tx_drain");
        do_read(ADDR_STATUS, "tx_drained");

        // RX path with interrupt
        do_write(ADDR_CTRL, 32'h12, "ctrl_rx_ie");
        step(0, 0, 3'd0, 0, 0, 1, 8'h3C, "rx_3c");
        do_read(ADDR_RXDATA, "rx_read_3c");
        do_read(ADDR_STATUS, "rx_empty_again");
        do_read(ADDR_RXDATA, "rx_read_empty");

        // RX full: simultaneous push and pop, then overflow, then set-beats-clear
        for (int i = 0; i < DEPTH; i++) step(0, 0, 3'd0, 0, 0, 1, 8'($urandom), "rx_fill");
        step(0, 1, ADDR_RXDATA, 0, 0, 1, 8'hE7, "rx_full_pushpop");
        do_read(ADDR_STATUS, "rx_full_status");
        step(0, 0, 3'd0, 0, 0, 1, 8'h11, "rx_overflow");
        do_read(ADDR_STATUS, "rx_ovf_status");
        step(1, 0, ADDR_STATUS, 32'h20, 0, 1, 8'h22, "rx_set_wins");
        do_read(ADDR_STATUS, "rx_set_wins_status");
        step(1, 1, ADDR_CTRL, 32'h12, 0, 0, 8'd0, "wr_rd_both");
        for (int i = 0; i < DEPTH; i++) do_read(ADDR_RXDATA, "rx_drain");
        do_write(ADDR_STATUS, 32'h30, "w1c_both");
        do_read(ADDR_STATUS, "status_clean");

        // BAUD coercion
        do_write(ADDR_BAUD, 32'hABCD_0000, "baud_zero");
        do_read(ADDR_BAUD, "baud_one");
        do_write(ADDR_BAUD, 32'h0000_1234, "baud_1234");
        do_read(ADDR_BAUD, "baud_read");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            r_k   = $urandom_range(0, 9);
            r_sel = 3'($urandom_range(0, 7));
            r_wd  = $urandom;
            if (r_sel == ADDR_CTRL) r_wd[1] = 1'b1;
            step(r_k < 4, (r_k >= 4) && (r_k < 8), r_sel, r_wd,
                 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                 8'($urandom), "rand");
        end

        // Asynchronous reset with both FIFOs half full
        do_write(ADDR_CTRL, 32'h2, "ctrl_rx_only");
        for (int i = 0; i < DEPTH / 2; i++)
            step(1, 0, ADDR_TXDATA, $urandom, 0, 1, 8'($urandom), "half_fill");
        async_reset("mid_reset");
        do_read(ADDR_BAUD, "post_rst_baud");
        do_read(ADDR_STATUS, "post_rst_status");
        chk("post_rst_status_const", m_status(), 32'h5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_apb_regs.md
Name: uart_apb_regs

Overview:
- UART register file and data buffering, directly downstream of the APB slave handshake stage.
- Consumes the one-cycle wr_en/rd_en strobes from that stage, together with the APB address and write data.
- Holds the control and baud registers, a TX FIFO feeding the UART transmitter and an RX FIFO filled by the UART receiver.
- Drives prdata and a level interrupt.

Parameters:
- FIFO_DEPTH, 16, entries per TX and RX FIFO; power of two, 2..256.
- ADDR_W, 5, width of paddr used for decode.
- BAUD_RST, 16'd27, reset value of the BAUD divisor.

Ports:
- sys_clk  in  1  single clock.
- sys_rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write strobe from the APB slave stage.
- rd_en  in  1  read strobe from the APB slave stage.
- paddr  in  ADDR_W  register address, stable while a strobe is high.
- pwdata  in  32  write data.
- prdata  out  32  read data, valid while rd_en=1.
- tx_data  out  8  head of the TX FIFO.
- tx_valid  out  1  TX FIFO non-empty and CTRL.tx_en=1.
- tx_ready  in  1  transmitter accepts tx_data; pops the FIFO when tx_valid&tx_ready.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle push strobe from the receiver.
- ctrl_out  out  5  CTRL[4:0] to the UART core.
- baud_div  out  16  BAUD register.
- irq  out  1  interrupt.

Behaviour:
- Decode uses paddr[4:2]; paddr[1:0] are ignored. Unmapped addresses read 0 and ignore writes.
- 0x00 TXDATA (W)
  - wr_en pushes pwdata[7:0] into the TX FIFO.
  - If the FIFO is full: data is dropped and STATUS.tx_ovf is set (sticky).
  - Reads return 0.
- 0x04 RXDATA (R)
  - Read returns {24'b0, RX head} combinationally while rd_en=1; the pop happens at the end of that cycle.
  - If RX is empty: returns 0, no pop, no state change.
  - Writes are ignored.
- 0x08 STATUS (R, W1C on bits 5:4)
  - Bit map: [0] tx_empty, [1] tx_full, [2] rx_empty, [3] rx_full, [4] tx_ovf, [5] rx_ovf, [31:6] = 0.
  - Writing 1 to bit 4 or 5 clears it.
  - If a set event and a clear occur in the same cycle, the set wins.
- 0x0C CTRL (RW), bits [4:0], reset 0
  - [0] tx_en, [1] rx_en, [2] parity_en, [3] parity_odd, [4] ie.
  - Upper bits read 0.
- 0x10 BAUD (RW), bits [15:0], reset BAUD_RST.
  - Writing 0 is coerced to 1.
- RX push: when rx_valid=1 and CTRL.rx_en=1, rx_data is pushed. If the RX FIFO is full, the byte is dropped and rx_ovf is set. When rx_en=0, rx_valid is ignored.
- Simultaneous push and pop on a FIFO:
  - Not full and not empty: both take effect and the count is unchanged.
  - Full: the pop completes first, so the push succeeds with no overflow.
  - Empty: the pop is ignored and the push succeeds.
- Register write latency: a written value is visible on the outputs and in a read one cycle after the wr_en cycle.
- TX latency: a byte written to an empty TX FIFO appears on tx_data, with tx_valid=1, in the cycle after wr_en.
- wr_en and rd_en are never high together; if they are, wr_en is honoured and rd_en is ignored (no pop).
- irq is registered:
  - irq = ie & (~rx_empty | tx_empty | tx_ovf | rx_ovf).
  - Updates one cycle after the causing event.
- Reset (async, mid-operation included):
  - FIFO pointers and counts go to 0.
  - tx_ovf, rx_ovf, CTRL, irq go to 0; BAUD goes to BAUD_RST.
  - Outputs: tx_valid=0, prdata=0, tx_data=0.
  - FIFO storage is not cleared.
- Pointers wrap modulo FIFO_DEPTH. Count width is $clog2(FIFO_DEPTH)+1.

Decomposition:
- Package uart_apb_pkg holds:
  - Register offsets: ADDR_TXDATA=3'd0, ADDR_RXDATA=3'd1, ADDR_STATUS=3'd2, ADDR_CTRL=3'd3, ADDR_BAUD=3'd4.
  - CTRL and STATUS bit-index constants.
- Sub-module uart_sync_fifo, instantiated twice (TX, RX):
  - Parameters WIDTH=8, DEPTH.
  - Ports push, pop, din, dout (head, combinational), full, empty, count.
  - Implements the simultaneous push/pop rules above.

Test Plan:
- Reset, then read STATUS, CTRL, BAUD -> 0x0000_0005, 0x0, 0x001B; irq=0, tx_valid=0.
- Write CTRL=0x1, write TXDATA 0xA5 with tx_ready=0 -> next cycle tx_valid=1, tx_data=0xA5, STATUS=0x4. Raise tx_ready for one cycle -> tx_valid=0, STATUS=0x5.
- With tx_en=0, write 17 bytes 0x00..0x10 -> STATUS=0x16 (tx_full, tx_ovf, rx_empty). Write STATUS=0x10 -> STATUS=0x6.
- CTRL=0x12 (rx_en, ie):
  - Pulse rx_valid with 0x3C -> irq=1 one cycle later.
  - Read RXDATA -> prdata=0x3C; next cycle STATUS shows rx_empty=1.
  - irq stays 1 because tx_empty=1.
- With RX FIFO full, pulse rx_valid and read RXDATA in the same cycle -> oldest byte returned, new byte stored, rx_ovf stays 0, count stays 16.
- Write BAUD=0 -> reads 0x0001. Assert sys_rst mid-transfer with both FIFOs half full -> counts 0 immediately, BAUD=0x001B, STATUS=0x5.
